incr_sweep_ctrl: RTL and testbench

- Controller that sequences the 4-bit incrementor (incrementor_4b) to sweep a value range and stream each value out over a valid/ready handshake.
- Latches start/end values on a start pulse, then emits start, start+1, … end inclusive, one beat per accepted transfer.
- Uses the incrementor's carry-out to detect 15→0 wrap, either terminating with an overflow flag or continuing through 0.
- Sits between a command source (test sequencer / address generator) and any consumer needing an ordered 4-bit value stream.

---
 rtl/incr_sweep_ctrl_pkg.sv | 14 +
 rtl/incr_sweep_ctrl_incrementor.sv | 10 +
 rtl/incr_sweep_ctrl.sv | 105 ++++++++++
 tb/tb_incr_sweep_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/incr_sweep_ctrl_pkg.sv
// Shared definitions for the incrementing sweep controller: datapath widths
// and the controller state encoding.
package incr_sweep_ctrl_pkg;

  localparam int WIDTH = 4;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/incr_sweep_ctrl_incrementor.sv
// 4-bit incrementor: out = num + 1 (mod 16), cout flags the 15 -> 0 wrap.
module incrementor_4b (
  input  logic [3:0] num,
  output logic [3:0] out,
  output logic       cout
);

  assign {cout, out} = {1'b0, num} + 5'd1;

endmodule

// File: rtl/incr_sweep_ctrl.sv
// Sweep controller: streams start_val..end_val (inclusive) over valid/ready,
// using the incrementor carry to either stop with overflow or wrap through 0.
module incr_sweep_ctrl #(
  parameter int WIDTH = incr_sweep_ctrl_pkg::WIDTH,
  parameter int CNT_W = incr_sweep_ctrl_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] start_val,
  input  logic [WIDTH-1:0] end_val,
  input  logic             wrap_en,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [CNT_W-1:0] beat_cnt
);

  import incr_sweep_ctrl_pkg::*;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] data_q, data_nxt;
  logic [WIDTH-1:0] end_q, end_nxt;
  logic             wrap_q, wrap_nxt;
  logic             ovf_q, ovf_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;

  logic [WIDTH-1:0] inc_out;
  logic             inc_cout;

  incrementor_4b u_inc (
    .num  (data_q),
    .out  (inc_out),
    .cout (inc_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      data_q <= '0;
      end_q  <= '0;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      state  <= state_nxt;
      data_q <= data_nxt;
      end_q  <= end_nxt;
      wrap_q <= wrap_nxt;
      ovf_q  <= ovf_nxt;
      cnt_q  <= cnt_nxt;
    end
  end

  // Abort outranks a same-cycle handshake, so its beat is never counted.
  always_comb begin
    state_nxt = state;
    data_nxt  = data_q;
    end_nxt   = end_q;
    wrap_nxt  = wrap_q;
    ovf_nxt   = ovf_q;
    cnt_nxt   = cnt_q;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_RUN;
          data_nxt  = start_val;
          end_nxt   = end_val;
          wrap_nxt  = wrap_en;
          ovf_nxt   = 1'b0;
          cnt_nxt   = '0;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (out_ready) begin
          cnt_nxt = cnt_q + CNT_W'(1);
          if (data_q == end_q) begin
            state_nxt = ST_DONE;
          end else if (inc_cout && !wrap_q) begin
            state_nxt = ST_DONE;
            ovf_nxt   = 1'b1;
          end else begin
            data_nxt = inc_out;
          end
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign out_valid = (state == ST_RUN);
  assign busy      = (state == ST_RUN);
  assign done      = (state == ST_DONE);
  assign out_data  = data_q;
  assign overflow  = ovf_q;
  assign beat_cnt  = cnt_q;

endmodule

// File: tb/tb_incr_sweep_ctrl.sv
// Bench for incr_sweep_ctrl: directed and randomized sweeps checked against
// an expected-beat list built from the sweep rules.
module tb_incr_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] start_val;
  logic [3:0] end_val;
  logic       wrap_en;
  logic       abort;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       busy;
  logic       done;
  logic       overflow;
  logic [4:0] beat_cnt;

  int vectors = 0;
  int miscompares = 0;

  incr_sweep_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .start_val (start_val),
    .end_val   (end_val),
    .wrap_en   (wrap_en),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow),
    .beat_cnt  (beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_data"},  32'(out_data), 0);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_done"},  32'(done), 0);
    chk({tag, "_ovf"},   32'(overflow), 0);
    chk({tag, "_cnt"},   32'(beat_cnt), 0);
  endtask

  // mode: 0 = ready always high, 1 = random ready plus stray start pulses,
  // 2 = ready pattern 0,0,1. abort_at = beat index at which to abort (-1 none).
  task automatic run_sweep(input logic [3:0] sv, input logic [3:0] ev, input logic wr,
                           input int mode, input int abort_at);
    logic [3:0] q[$];
    logic [3:0] v;
    logic       exp_ovf;
    logic       r;
    int         idx;
    int         cyc;
    bit         fin;

    q.delete();
    v = sv;
    exp_ovf = 1'b0;
    for (int k = 0; k < 16; k++) begin
      q.push_back(v);
      if (v == ev) break;
      if (v == 4'd15 && !wr) begin
        exp_ovf = 1'b1;
        break;
      end
      v = v + 4'd1;
    end

    start = 1'b1; start_val = sv; end_val = ev; wrap_en = wr; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("first_busy", 32'(busy), 1);
    chk("first_cnt", 32'(beat_cnt), 0);
    chk("first_ovf", 32'(overflow), 0);

    idx = 0; cyc = 0; fin = 0;
    while (!fin) begin
      if (cyc >= 200) begin
        vectors++;
        miscompares++;
        $error("FAIL timeout: sweep %0d..%0d still running after %0d cycles", sv, ev, cyc);
        fin = 1;
      end else begin
        chk("valid", 32'(out_valid), 1);
        chk("data", 32'(out_data), 32'(q[idx]));
        chk("cnt", 32'(beat_cnt), idx);
        if (abort_at == idx) begin
          abort = 1'b1; out_ready = 1'b1;
          @(negedge clk);
          abort = 1'b0; out_ready = 1'b0;
          chk("abort_valid", 32'(out_valid), 0);
          chk("abort_busy", 32'(busy), 0);
          chk("abort_done", 32'(done), 0);
          chk("abort_cnt", 32'(beat_cnt), idx);
          @(negedge clk);
          chk("abort_nodone", 32'(done), 0);
          fin = 1;
        end else begin
          case (mode)
            0:       r = 1'b1;
            1:       r = 1'($urandom_range(0, 1));
            default: r = (cyc % 3 == 2);
          endcase
          out_ready = r;
          start = (mode == 1) && ($urandom_range(0, 3) == 0);
          if (start) begin
            start_val = 4'($urandom); end_val = 4'($urandom); wrap_en = 1'($urandom);
          end
          @(negedge clk);
          cyc++;
          start = 1'b0;
          if (r) idx++;
          if (idx == q.size()) begin
            out_ready = 1'b0;
            chk("done", 32'(done), 1);
            chk("done_busy", 32'(busy), 0);
            chk("done_valid", 32'(out_valid), 0);
            chk("ovf", 32'(overflow), 32'(exp_ovf));
            chk("cnt_final", 32'(beat_cnt), q.size());
            start = 1'b1; start_val = 4'($urandom); end_val = 4'($urandom);
            @(negedge clk);
            start = 1'b0;
            chk("idle_valid", 32'(out_valid), 0);
            chk("idle_done", 32'(done), 0);
            chk("idle_busy", 32'(busy), 0);
            chk("ovf_sticky", 32'(overflow), 32'(exp_ovf));
            chk("cnt_hold", 32'(beat_cnt), q.size());
            fin = 1;
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start_val = 4'd0; end_val = 4'd0;
    wrap_en = 1'b0; abort = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);

    run_sweep(4'd2, 4'd5, 1'b0, 0, -1);
    run_sweep(4'd14, 4'd1, 1'b0, 0, -1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_clears_ovf", 32'(overflow), 0);
    chk("rst_clears_cnt", 32'(beat_cnt), 0);
    run_sweep(4'd14, 4'd1, 1'b1, 0, -1);
    run_sweep(4'd7, 4'd7, 1'b0, 2, -1);
    run_sweep(4'd0, 4'd15, 1'b0, 0, 3);
    run_sweep(4'd4, 4'd6, 1'b0, 0, -1);
    run_sweep(4'd6, 4'd5, 1'b1, 0, -1);

    // Stray start during RUN must not relatch end_val; then reset mid-sweep.
    start = 1'b1; start_val = 4'd3; end_val = 4'd9; wrap_en = 1'b0;
    @(negedge clk);
    chk("rs_data0", 32'(out_data), 3);
    out_ready = 1'b1; start = 1'b1; start_val = 4'd0; end_val = 4'd4;
    @(negedge clk);
    start = 1'b0;
    chk("rs_data1", 32'(out_data), 4);
    @(negedge clk);
    chk("rs_data2", 32'(out_data), 5);
    chk("rs_busy", 32'(busy), 1);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0; out_ready = 1'b0;
    chk_reset_vals("midrun_rst");
    @(negedge clk);
    chk("post_rst_idle", 32'(out_valid), 0);

    for (int n = 0; n < 40; n++) begin
      run_sweep(4'($urandom), 4'($urandom), 1'($urandom), $urandom_range(0, 2),
                ($urandom_range(0, 4) == 0) ? $urandom_range(0, 15) : -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
